// File: rtl/bo_arbiter.sv
// Purpose : two-requester round-robin arbiter/sequencer in front of the shared
//           polynomial datapath; loads the winner's operand, holds dp_inicio for
//           one control-block pass, captures the result and answers req/done.
// Latency : request sampled at E0 -> done/y_out valid after E(SEQ_LEN+1).
// Backpressure: a waiting requester is held off until the current job's
//           4-phase handshake completes; done is held until its req drops.
//
// Ports:
//   clk, reset         - clock, synchronous active-low reset
//   req0/x0, req1/x1   - per-requester request level and operand
//   done0/done1, y_out - per-requester completion flag and captured result
//   grant, busy        - one-hot current owner, non-idle indicator
//   dp_x, dp_inicio    - operand and start/enable towards datapath/control block
//   dp_result          - datapath result register
module bo_arbiter #(
  parameter int DATA_W  = 8,
  parameter int SEQ_LEN = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] x0,
  input  logic              req1,
  input  logic [DATA_W-1:0] x1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] y_out,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [DATA_W-1:0] dp_x,
  output logic              dp_inicio,
  input  logic [DATA_W-1:0] dp_result
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Last RUN cycle: cnt counts 0..SEQ_LEN-1 while dp_inicio is high.
  localparam logic [7:0] LAST_CNT = 8'(SEQ_LEN - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              lp_q, lp_d;     // index of the last requester served
  logic              g_q, g_d;       // index of the current owner
  logic [1:0]        grant_q, grant_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [DATA_W-1:0] dp_x_q, dp_x_d;
  logic              inicio_q, inicio_d;
  logic              busy_q, busy_d;

  // Arbitration (only acted on in IDLE): on a tie the requester that was not
  // served last wins; otherwise whoever is asking wins.
  logic any_req;
  logic win;
  logic req_g;

  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      win = ~lp_q;
    end else begin
      win = req1;
    end
    req_g = g_q ? req1 : req0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lp_d     = lp_q;
    g_d      = g_q;
    grant_d  = grant_q;
    done0_d  = done0_q;
    done1_d  = done1_q;
    y_d      = y_q;
    dp_x_d   = dp_x_q;
    inicio_d = inicio_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          g_d      = win;
          grant_d  = win ? 2'b10 : 2'b01;
          dp_x_d   = win ? x1 : x0;
          inicio_d = 1'b1;
          cnt_d    = 8'd0;
          state_d  = RUN;
        end
      end

      RUN: begin
        // The owner's req is deliberately ignored here: a started control
        // sequence always runs to completion.
        if (cnt_q == LAST_CNT) begin
          inicio_d = 1'b0;
          state_d  = CAPTURE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      CAPTURE: begin
        // dp_result is taken one cycle after dp_inicio falls.
        y_d = dp_result;
        if (g_q) begin
          done1_d = 1'b1;
        end else begin
          done0_d = 1'b1;
        end
        state_d = RESP;
      end

      RESP: begin
        if (!req_g) begin
          done0_d = 1'b0;
          done1_d = 1'b0;
          grant_d = 2'b00;
          lp_d    = g_q;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      lp_q     <= 1'b1;
      g_q      <= 1'b0;
      grant_q  <= 2'b00;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      y_q      <= '0;
      dp_x_q   <= '0;
      inicio_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lp_q     <= lp_d;
      g_q      <= g_d;
      grant_q  <= grant_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      y_q      <= y_d;
      dp_x_q   <= dp_x_d;
      inicio_q <= inicio_d;
      busy_q   <= busy_d;
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign y_out     = y_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign dp_x      = dp_x_q;
  assign dp_inicio = inicio_q;

endmodule

// File: tb/tb_bo_arbiter.sv
// Purpose : self-checking bench for bo_arbiter (directed table, corner
//           sequences, randomized traffic against a cycle-count reference model).
// Latency : datapath stand-in returns dp_x+3 combinationally.
// Backpressure: bench requesters obey the req/done 4-phase handshake.
module tb_bo_arbiter;

  localparam int DATA_W  = 8;
  localparam int SEQ_LEN = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1;
  logic [DATA_W-1:0] x0, x1;
  logic              done0, done1;
  logic [DATA_W-1:0] y_out;
  logic [1:0]        grant;
  logic              busy;
  logic [DATA_W-1:0] dp_x;
  logic              dp_inicio;
  logic [DATA_W-1:0] dp_result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign dp_result = dp_x + 8'd3;

  bo_arbiter #(.DATA_W(DATA_W), .SEQ_LEN(SEQ_LEN)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .x0(x0), .req1(req1), .x1(x1),
    .done0(done0), .done1(done1), .y_out(y_out),
    .grant(grant), .busy(busy), .dp_x(dp_x),
    .dp_inicio(dp_inicio), .dp_result(dp_result)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after E0 with dp_inicio expected high; returns how many
  // consecutive cycles dp_inicio stayed high. Bounded so it cannot hang.
  task automatic count_inicio(output int n);
    n = dp_inicio ? 1 : 0;
    while (dp_inicio && n < 200) begin
      step();
      if (dp_inicio) n++;
    end
  endtask

  task automatic wait_done(input bit which, input string name);
    int cyc = 0;
    while (!(which ? done1 : done0) && cyc < 60) begin
      step();
      cyc++;
    end
    chk(name, (which ? done1 : done0), 1'b1);
  endtask

  typedef struct {
    logic       r0;
    logic       r1;
    logic [7:0] x0v;
    logic [7:0] x1v;
    logic [1:0] egrant;
    logic [7:0] edpx;
    logic [7:0] ey;
  } vec_t;

  vec_t tbl[8];

  // Reference model state: one job at a time, tracked by edges since grant.
  int         m_owner;
  int         m_k;
  int         m_lp;
  logic       m_done;
  logic [7:0] m_y;
  logic [7:0] m_dpx;

  task automatic model_reset();
    m_owner = -1; m_k = 0; m_lp = 1; m_done = 1'b0; m_y = 8'h00; m_dpx = 8'h00;
  endtask

  // Advance the model by one edge using the inputs present at that edge.
  task automatic model_edge(input logic rst_n, input logic r0, input logic r1,
                            input logic [7:0] a0, input logic [7:0] a1);
    int g;
    logic rg;
    if (!rst_n) begin
      model_reset();
    end else if (m_owner < 0) begin
      if (r0 || r1) begin
        if (r0 && r1) g = (m_lp == 0) ? 1 : 0;
        else          g = r1 ? 1 : 0;
        m_owner = g;
        m_k     = 0;
        m_dpx   = (g == 1) ? a1 : a0;
      end
    end else begin
      m_k++;
      rg = (m_owner == 1) ? r1 : r0;
      if (m_k == SEQ_LEN + 1) begin
        m_y    = m_dpx + 8'd3;
        m_done = 1'b1;
      end else if (m_k > SEQ_LEN + 1 && !rg) begin
        m_done  = 1'b0;
        m_lp    = m_owner;
        m_owner = -1;
      end
    end
  endtask

  initial begin
    int n;
    logic dn;
    logic rq[2];
    logic [7:0] exp_vec, act_vec;

    // Directed table: each record is one whole job started from IDLE.
    tbl[0] = '{1'b1, 1'b1, 8'h10, 8'h20, 2'b01, 8'h10, 8'h13};
    tbl[1] = '{1'b1, 1'b1, 8'h10, 8'h20, 2'b10, 8'h20, 8'h23};
    tbl[2] = '{1'b1, 1'b1, 8'h40, 8'h20, 2'b01, 8'h40, 8'h43};
    tbl[3] = '{1'b1, 1'b1, 8'h40, 8'h55, 2'b10, 8'h55, 8'h58};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 8'hFE, 2'b10, 8'hFE, 8'h01};
    tbl[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 2'b01, 8'hFF, 8'h02};
    tbl[6] = '{1'b0, 1'b1, 8'h00, 8'h7F, 2'b10, 8'h7F, 8'h82};
    tbl[7] = '{1'b1, 1'b1, 8'h00, 8'h99, 2'b01, 8'h00, 8'h03};

    // Reset held two edges with both requests asserted.
    reset = 1'b0; req0 = 1'b1; req1 = 1'b1; x0 = 8'hAA; x1 = 8'hBB;
    step(); step();
    chk("reset_outputs", {grant, busy, dp_inicio, done0, done1, dp_x, y_out}, 64'h0);
    reset = 1'b1;
    step();
    chk("reset_first_grant", grant, 2'b01);
    chk("reset_first_dpx", dp_x, 8'hAA);
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1; x0 = tbl[i].x0v; x1 = tbl[i].x1v;
      step();
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].egrant);
      chk($sformatf("tbl%0d_dpx", i), dp_x, tbl[i].edpx);
      count_inicio(n);
      chk($sformatf("tbl%0d_inicio_len", i), n, SEQ_LEN);
      step();
      chk($sformatf("tbl%0d_done", i), {done1, done0}, tbl[i].egrant);
      chk($sformatf("tbl%0d_y", i), y_out, tbl[i].ey);
      req0 = 1'b0; req1 = 1'b0;
      step();
      chk($sformatf("tbl%0d_release", i), {done0, done1, grant, busy}, 5'b0);
    end

    // Contention: req1 arrives mid-RUN of requester 0 and is served next.
    req0 = 1'b1; x0 = 8'h10;
    step();
    chk("cont_grant0", grant, 2'b01);
    repeat (5) step();
    req1 = 1'b1; x1 = 8'hFE;
    wait_done(1'b0, "cont_done0");
    chk("cont_y0", y_out, 8'h13);
    chk("cont_hold_grant0", grant, 2'b01);
    req0 = 1'b0;
    step();
    chk("cont_idle_gap", {grant, done0}, 3'b000);
    step();
    chk("cont_grant1", grant, 2'b10);
    chk("cont_dpx1", dp_x, 8'hFE);
    wait_done(1'b1, "cont_done1");
    chk("cont_y1_wrap", y_out, 8'h01);
    req1 = 1'b0;
    step();
    chk("cont_end_idle", {busy, done1}, 2'b00);

    // Early drop at RUN cycle 5: sequence still full length, done pulses once.
    req0 = 1'b1; x0 = 8'h20;
    step();
    n = 1;
    for (int c = 1; c < 200 && dp_inicio; c++) begin
      if (c == 5) req0 = 1'b0;
      step();
      if (dp_inicio) n++;
    end
    chk("early_inicio_len", n, SEQ_LEN);
    step();
    chk("early_done_hi", {done0, y_out}, {1'b1, 8'h23});
    step();
    chk("early_done_lo", {done0, busy, grant}, 4'b0000);

    // Reset at RUN cycle 10.
    req0 = 1'b1; x0 = 8'h30;
    step();
    repeat (9) step();
    reset = 1'b0;
    step();
    chk("midrst_outputs", {dp_inicio, grant, busy}, 4'b0000);
    req0 = 1'b0; reset = 1'b1;
    dn = 1'b0;
    repeat (25) begin
      step();
      if (done0 || done1) dn = 1'b1;
    end
    chk("midrst_no_done", dn, 1'b0);
    req0 = 1'b1; x0 = 8'h31;
    step();
    count_inicio(n);
    chk("midrst_rerun_len", n, SEQ_LEN);
    step();
    chk("midrst_rerun_done", {done0, y_out}, {1'b1, 8'h34});
    req0 = 1'b0;
    step();

    // Randomized traffic against the reference model.
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    step();
    model_reset();
    reset = 1'b1;
    rq[0] = 1'b0; rq[1] = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rq[i]) begin
          if ($urandom_range(3) == 0) begin
            rq[i] = 1'b1;
            if (i == 0) x0 = 8'($urandom);
            else        x1 = 8'($urandom);
          end
        end else if (m_done && m_owner == i) begin
          if ($urandom_range(1) == 0) rq[i] = 1'b0;
        end else if ($urandom_range(99) == 0) begin
          rq[i] = 1'b0;
        end
      end
      req0  = rq[0];
      req1  = rq[1];
      reset = ($urandom_range(499) == 0) ? 1'b0 : 1'b1;
      @(posedge clk);
      model_edge(reset, req0, req1, x0, x1);
      #1;
      exp_vec = {1'b0,
                 (m_owner == 1), (m_owner == 0),
                 (m_owner >= 0),
                 (m_owner >= 0 && m_k < SEQ_LEN),
                 (m_done && m_owner == 0),
                 (m_done && m_owner == 1),
                 1'b0};
      act_vec = {1'b0, grant, busy, dp_inicio, done0, done1, 1'b0};
      chk("rand_ctrl", {act_vec, dp_x, y_out}, {exp_vec, m_dpx, m_y});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
